// File: rtl/online_stream_checker.sv
// Drives two signed-digit operands serially into an online adder under test,
// captures its result digits and judges the result by numerical value.
module online_stream_checker #(
  parameter int N     = 6,
  parameter int C     = 3,
  parameter int DELTA = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N*C-1:0] x_vec,
  input  logic [N*C-1:0] y_vec,
  output logic [C-1:0]   x_dig,
  output logic [C-1:0]   y_dig,
  output logic           dig_valid,
  input  logic [C-1:0]   z_dig,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           digit_err,
  output logic [15:0]    pass_count,
  output logic [15:0]    fail_count
);
  // One guard bit above the largest (N+1)-digit result magnitude plus sign.
  localparam int W    = (N + 1) * (C - 1) + 2;
  localparam int LAST = N + DELTA;
  localparam int CW   = $clog2(LAST + 2);
  localparam logic [C-1:0] ILLEGAL = {1'b1, {(C-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r;
  logic [N*C-1:0]       x_lat_r, y_lat_r, x_sh_r, y_sh_r;
  logic [(N+1)*C-1:0]   z_cap_r;
  logic [C-1:0]         x_dig_s, y_dig_s;
  logic                 valid_s, illegal_s, pass_s;
  logic signed [W-1:0]  sum_s, z_val_s;

  function automatic logic signed [W-1:0] digit_value(input logic [C-1:0] d);
    return {{(W-C){d[C-1]}}, d};
  endfunction

  // Digit k (MSD first) sits at bits [(N-k)*C +: C].
  function automatic logic signed [W-1:0] digits_value(input logic [(N+1)*C-1:0] v);
    logic signed [W-1:0] acc;
    acc = '0;
    for (int k = N; k >= 0; k--) begin
      acc = (acc <<< (C - 1)) + digit_value(v[k*C +: C]);
    end
    return acc;
  endfunction

  function automatic logic is_illegal(input logic [C-1:0] d);
    return (d == ILLEGAL);
  endfunction

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = DRIVE; else state_s = IDLE;
      DRIVE:   if (cnt_r == CW'(LAST)) state_s = CHECK; else state_s = DRIVE;
      CHECK:   state_s = REPORT;
      REPORT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next value of the registered digit stream outputs.
  always_comb begin
    x_dig_s = '0;
    y_dig_s = '0;
    valid_s = 1'b0;
    if (state_r == IDLE && start) begin
      x_dig_s = x_vec[N*C-1 -: C];
      y_dig_s = y_vec[N*C-1 -: C];
      valid_s = 1'b1;
    end else if (state_r == DRIVE && state_s == DRIVE) begin
      x_dig_s = x_sh_r[N*C-C-1 -: C];
      y_dig_s = y_sh_r[N*C-C-1 -: C];
      valid_s = 1'b1;
    end else begin
      x_dig_s = '0;
      y_dig_s = '0;
      valid_s = 1'b0;
    end
  end

  // Value-based verdict on the captured result.
  always_comb begin
    illegal_s = 1'b0;
    for (int k = 0; k <= N; k++) begin
      illegal_s = illegal_s | is_illegal(z_cap_r[k*C +: C]);
    end
    sum_s   = digits_value({{C{1'b0}}, x_lat_r}) + digits_value({{C{1'b0}}, y_lat_r});
    z_val_s = digits_value(z_cap_r);
    pass_s  = !illegal_s && (z_val_s == sum_s);
  end

  // State, datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      x_lat_r    <= '0;
      y_lat_r    <= '0;
      x_sh_r     <= '0;
      y_sh_r     <= '0;
      z_cap_r    <= '0;
      x_dig      <= '0;
      y_dig      <= '0;
      dig_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      digit_err  <= 1'b0;
      pass_count <= 16'd0;
      fail_count <= 16'd0;
    end else begin
      state_r   <= state_s;
      x_dig     <= x_dig_s;
      y_dig     <= y_dig_s;
      dig_valid <= valid_s;
      busy      <= (state_s != IDLE);
      done      <= (state_r == CHECK);
      if (state_r == IDLE && start) begin
        x_lat_r <= x_vec;
        y_lat_r <= y_vec;
        x_sh_r  <= x_vec;
        y_sh_r  <= y_vec;
        cnt_r   <= '0;
      end else if (state_r == DRIVE) begin
        cnt_r  <= cnt_r + CW'(1);
        x_sh_r <= x_sh_r << C;
        y_sh_r <= y_sh_r << C;
        // Result digits arrive DELTA cycles late; exactly N+1 are shifted in.
        if (cnt_r >= CW'(DELTA)) begin
          z_cap_r <= {z_cap_r[N*C-1:0], z_dig};
        end
      end
      if (state_r == CHECK) begin
        pass      <= pass_s;
        digit_err <= illegal_s;
        if (pass_s) begin
          if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
        end else begin
          if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/online_stream_checker.md
ONLINE_STREAM_CHECKER -- requirements
Module: online_stream_checker

Interface
REQ-001 SHALL have parameter N, default 6: digits per operand.
REQ-002 SHALL have parameter C, default 3: bits per digit; radix r = 2^(C-1); legal digits -(r-1)..+(r-1), two's complement per digit.
REQ-003 SHALL have parameter DELTA, default 2: online delay of the adder under test, in cycles.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  request one test; sampled only in IDLE.
REQ-007 x_vec  in  N*C  first operand, MSD in top C bits.
REQ-008 y_vec  in  N*C  second operand, same packing.
REQ-009 x_dig  out  C  serial x digit to adder under test.
REQ-010 y_dig  out  C  serial y digit to adder under test.
REQ-011 dig_valid  out  1  high while x_dig/y_dig are being driven.
REQ-012 z_dig  in  C  serial result digit from adder under test.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse: test result valid.
REQ-015 pass  out  1  result of last test; held until next done.
REQ-016 digit_err  out  1  last test captured an illegal z digit (code 1 followed by C-1 zeros); held until next done.
REQ-017 pass_count, fail_count  out  16 each  completed-test counters.

Function
REQ-018 SHALL implement states IDLE, DRIVE, CHECK, REPORT; IDLE->DRIVE on start, DRIVE->CHECK after N+DELTA+1 cycles, CHECK->REPORT, REPORT->IDLE, each after one cycle.
REQ-019 SHALL latch x_vec and y_vec on the edge that samples start in IDLE; later input changes SHALL NOT affect the running test.
REQ-020 SHALL, in DRIVE cycle i (i = 0..N+DELTA), drive x_dig/y_dig with operand digit i (MSD first) for i < N and zero otherwise, with dig_valid high; outside DRIVE, x_dig = y_dig = 0 and dig_valid = 0.
REQ-021 SHALL capture z_dig at the end of DRIVE cycles i = DELTA..DELTA+N as result digits k = 0..N (k = 0 MSD).
REQ-022 SHALL evaluate by value, not digit pattern: X = sum x_k*r^(N-1-k), Y likewise, Z = sum z_k*r^(N-k); pass = (Z == X+Y) and no illegal digit captured.
REQ-023 SHALL compute all values in signed arithmetic of at least N*(C-1)+3 bits with no overflow at any legal operand/result.
REQ-024 SHALL flag digit_err and fail the test if any captured z digit is the illegal code; the value comparison result is irrelevant in that case.
REQ-025 SHALL, on the edge leaving CHECK, register pass and digit_err, assert done for exactly the REPORT cycle, and increment pass_count or fail_count by one.
REQ-026 SHALL make done visible on the edge N+DELTA+2 after the start-sampling edge (N=6, DELTA=2: edge 10).
REQ-027 SHALL ignore start while busy; no queueing. start high in REPORT SHALL be ignored; start in IDLE the following cycle SHALL be accepted.
REQ-028 SHALL saturate pass_count and fail_count at 16'hFFFF.
REQ-029 SHALL accept back-to-back tests: start held high continuously yields one test every N+DELTA+4 cycles.

Reset
REQ-030 SHALL, on reset high at a rising edge, enter IDLE and clear busy, done, pass, digit_err, dig_valid, x_dig, y_dig, pass_count, fail_count and all captured digits.
REQ-031 SHALL let reset override start and abort any test in progress with no done pulse and no counter change.

Verification
REQ-032 x = y = six digits 1, DUT model returns {0,2,2,2,2,2,2} at DELTA=2 -> done at edge 10, pass=1, pass_count=1.
REQ-033 x = six digits 2, y = six digits 1, DUT returns {1,0,0,0,0,0,-1} (value 4095) -> pass=1 despite non-canonical digits.
REQ-034 Same operands, DUT returns {1,0,0,0,0,0,0} -> pass=0, digit_err=0, fail_count=1.
REQ-035 DUT returns code 3'b100 in digit 3 -> pass=0, digit_err=1, fail_count increments.
REQ-036 start pulsed again at DRIVE cycle 3, x_vec changed mid-test -> ignored, result uses latched operands, one done only.
REQ-037 reset asserted in DRIVE cycle 4 -> IDLE next cycle, all outputs zero, no done, counters zero; new start then completes normally.
